instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/tproc_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/tproc_pkg.sv
// Shared definitions for the instruction fetch path: widths, END opcode location and
// the fetch FSM state type.
package tproc_pkg;

    localparam int unsigned INSTR_W = 64;
    localparam int unsigned ADDR_W  = 16;

    localparam int unsigned OPC_MSB = 63;
    localparam int unsigned OPC_LSB = 60;
    localparam logic [3:0]  END_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } fetch_state_e;

    function automatic logic is_end_opcode(input logic [3:0] opc);
        return opc == END_OPCODE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; read data comes straight from the head entry
// register and reads as zero while empty.
module sync_fifo
    import tproc_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Pop on empty is dropped; a push into a full buffer only lands if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: streams instruction memory from BASE_ADDR into a prefetch
// buffer until an END instruction is fetched, then drains the buffer to the decoder.
module instr_fetch_unit #(
    parameter int unsigned       INSTR_W    = tproc_pkg::INSTR_W,
    parameter int unsigned       ADDR_W     = tproc_pkg::ADDR_W,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acc_enable,
    input  logic [INSTR_W-1:0] instr_port,
    output logic [ADDR_W-1:0]  instr_fetch_addr,
    output logic               instr_rd_en,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy,
    output logic               done
);
    import tproc_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic              fetch_end;

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;

    // Room is judged after this cycle's pop, so a full buffer still refills when the
    // decoder takes the head in the same cycle.
    assign instr_rd_en = (state_q == FETCH) &&
                         ((fifo_count - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH));

    assign fetch_end = instr_rd_en && is_end_opcode(instr_port[OPC_MSB:OPC_LSB]);

    // Only the END word can be the last one in the buffer, so done fires on its hand-off.
    assign done = (state_q == DRAIN) && pop && is_end_opcode(instr_out[OPC_MSB:OPC_LSB]);

    assign busy             = (state_q != IDLE);
    assign instr_fetch_addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc_enable) begin
                        state_q <= FETCH;
                        addr_q  <= BASE_ADDR;
                    end
                end
                FETCH: begin
                    if (instr_rd_en) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (fetch_end) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (state_q == FINISH),
        .push  (instr_rd_en),
        .wdata (instr_port),
        .pop   (pop),
        .rdata (instr_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    overflow_guard: assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && instr_rd_en && !pop));

endmodule
